// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between two requesters, the arbiter and a shared FIFO.
// slave: arbiter view; master: requester/FIFO/monitor view.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             ack0;
    logic             ack1;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [WIDTH-1:0] fifo_data_in;
    logic [1:0]       owner;
    logic [15:0]      wr_count;

    modport slave (
        input  req0, req1, data0, data1, fifo_full,
        output ack0, ack1, fifo_wr_en, fifo_data_in, owner, wr_count
    );

    modport master (
        output req0, req1, data0, data1, fifo_full,
        input  ack0, ack1, fifo_wr_en, fifo_data_in, owner, wr_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Two-requester write arbiter with burst-limited round robin into one FIFO.
// Ports: clk, rst_n (async, active low), bus (slave side of fifo_wr_arbiter_if).
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [1:0]  state_q, state_d;
    logic        last_q, last_d;
    logic [3:0]  burst_q, burst_d;
    logic [15:0] wr_count_q, wr_count_d;

    logic ack0, ack1, burst_hit;

    always_comb begin
        ack0 = (state_q == OWN0) && bus.req0 && !bus.fifo_full;
        ack1 = (state_q == OWN1) && bus.req1 && !bus.fifo_full;
        burst_hit = (burst_q + 4'd1) == BURST_MAX;

        bus.ack0       = ack0;
        bus.ack1       = ack1;
        bus.fifo_wr_en = ack0 || ack1;
        bus.owner      = state_q;
        bus.wr_count   = wr_count_q;

        // Data follows the owner even in stall cycles; zero when idle.
        unique case (state_q)
            OWN0:    bus.fifo_data_in = bus.data0;
            OWN1:    bus.fifo_data_in = bus.data1;
            default: bus.fifo_data_in = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        burst_d    = burst_q;
        wr_count_d = wr_count_q + 16'(bus.fifo_wr_en);

        unique case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1)
                    state_d = last_q ? OWN0 : OWN1;
                else if (bus.req0)
                    state_d = OWN0;
                else if (bus.req1)
                    state_d = OWN1;
            end
            OWN0: begin
                if (!bus.req0)
                    state_d = bus.req1 ? OWN1 : IDLE;
                else if (ack0 && burst_hit) begin
                    // Burst limit only yields if someone is waiting.
                    if (bus.req1)
                        state_d = OWN1;
                    else
                        burst_d = '0;
                end else if (ack0)
                    burst_d = burst_q + 4'd1;
            end
            OWN1: begin
                if (!bus.req1)
                    state_d = bus.req0 ? OWN0 : IDLE;
                else if (ack1 && burst_hit) begin
                    if (bus.req0)
                        state_d = OWN0;
                    else
                        burst_d = '0;
                end else if (ack1)
                    burst_d = burst_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            burst_d = '0;
            if (state_d == OWN0)
                last_d = 1'b0;
            else if (state_d == OWN1)
                last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            burst_q    <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            wr_count_q <= wr_count_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic against a cycle-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;
    localparam int W  = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.WIDTH(W)) bus ();

    fifo_wr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: who owns the FIFO (0 none, 1 req0, 2 req1).
    int m_cur, m_last, m_burst, m_cnt;
    logic e_ack0, e_ack1, e_wr;
    logic [W-1:0] e_data;
    logic [1:0] e_owner;
    logic [15:0] e_cnt;

    logic [W-1:0] base0, base1;
    int idx0, idx1;

    logic [28:0] obs, exp_v;

    function automatic void mdl_reset();
        m_cur = 0; m_last = 1; m_burst = 0; m_cnt = 0;
    endfunction

    function automatic void mdl_eval();
        e_ack0 = (m_cur == 1) && bus.req0 && !bus.fifo_full;
        e_ack1 = (m_cur == 2) && bus.req1 && !bus.fifo_full;
        e_wr = e_ack0 || e_ack1;
        e_data = (m_cur == 1) ? bus.data0 : (m_cur == 2) ? bus.data1 : '0;
        e_owner = 2'(m_cur);
        e_cnt = 16'(m_cnt);
        exp_v = {e_ack0, e_ack1, e_wr, e_owner, e_data, e_cnt};
        obs = {bus.ack0, bus.ack1, bus.fifo_wr_en, bus.owner,
               bus.fifo_data_in, bus.wr_count};
    endfunction

    function automatic void mdl_step();
        bit r0, r1, f, rk, ro, acc;
        int nxt;
        r0 = bus.req0; r1 = bus.req1; f = bus.fifo_full;
        acc = 0; nxt = m_cur;
        if (m_cur == 0) begin
            if (r0 && r1) nxt = (m_last == 1) ? 1 : 2;
            else if (r0) nxt = 1;
            else if (r1) nxt = 2;
        end else begin
            rk = (m_cur == 1) ? r0 : r1;
            ro = (m_cur == 1) ? r1 : r0;
            acc = rk && !f;
            if (!rk) nxt = ro ? 3 - m_cur : 0;
            else if (acc) begin
                m_burst++;
                if (m_burst == MB) begin
                    m_burst = 0;
                    if (ro) nxt = 3 - m_cur;
                end
            end
        end
        if (nxt != m_cur) begin
            m_burst = 0;
            if (nxt != 0) m_last = nxt - 1;
        end
        m_cur = nxt;
        if (acc) m_cnt = (m_cnt + 1) % 65536;
    endfunction

    // Advance one clock: model and requesters consume acks at the edge.
    task automatic tick();
        bit a0, a1;
        @(posedge clk);
        a0 = (m_cur == 1) && bus.req0 && !bus.fifo_full;
        a1 = (m_cur == 2) && bus.req1 && !bus.fifo_full;
        mdl_step();
        if (a0) idx0++;
        if (a1) idx1++;
        #1;
        bus.data0 = W'(base0 + W'(idx0));
        bus.data1 = W'(base1 + W'(idx1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.fifo_full = 0;
        idx0 = 0; idx1 = 0;
        bus.data0 = base0; bus.data1 = base1;
        mdl_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        base0 = 8'h10; base1 = 8'h80;
        rst_n = 1'b0;
        bus.req0 = 1; bus.req1 = 1; bus.fifo_full = 0;
        bus.data0 = base0; bus.data1 = base1;
        #3;
        obs = {bus.ack0, bus.ack1, bus.fifo_wr_en, bus.owner,
               bus.fifo_data_in, bus.wr_count};
        total_cnt++;
        if (obs !== 29'd0)
            $display("FAIL reset outputs: got %h want 0", obs);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_single();
        logic [W-1:0] wq[$];
        int cyc = 0, first_wr = -1;
        logic [1:0] wown = 2'b00;
        base0 = 8'd1; base1 = 8'h55;
        do_reset();
        bus.req0 = 1;
        while (idx0 < 6 && cyc < 20) begin
            @(negedge clk);
            mdl_eval();
            total_cnt++;
            if (obs !== exp_v)
                $display("FAIL single cyc%0d: got %h want %h", cyc, obs, exp_v);
            else pass_cnt++;
            if (bus.fifo_wr_en) begin
                wq.push_back(bus.fifo_data_in);
                if (first_wr < 0) first_wr = cyc;
                wown = bus.owner;
            end
            cyc++;
            tick();
        end
        bus.req0 = 0;
        total_cnt++;
        if (first_wr !== 1)
            $display("FAIL single first_wr: got %0d want 1", first_wr);
        else pass_cnt++;
        total_cnt++;
        if (wq.size() != 6)
            $display("FAIL single nwrites: got %0d want 6", wq.size());
        else pass_cnt++;
        foreach (wq[i]) begin
            total_cnt++;
            if (wq[i] !== W'(i + 1))
                $display("FAIL single data%0d: got %0d want %0d", i, wq[i], i + 1);
            else pass_cnt++;
        end
        total_cnt++;
        if (wown !== 2'b01 || bus.wr_count !== 16'd6)
            $display("FAIL single owner/count: got %b/%0d want 01/6",
                     wown, bus.wr_count);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        int who, want;
        base0 = 8'h20; base1 = 8'hA0;
        do_reset();
        bus.req0 = 1; bus.req1 = 1;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            mdl_eval();
            total_cnt++;
            if (obs !== exp_v)
                $display("FAIL contention cyc%0d: got %h want %h", c, obs, exp_v);
            else pass_cnt++;
            who = bus.ack0 ? 0 : bus.ack1 ? 1 : -1;
            want = (c == 0) ? -1 : ((c - 1) / MB) % 2;
            total_cnt++;
            if (who != want)
                $display("FAIL contention pattern cyc%0d: got %0d want %0d",
                         c, who, want);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_stall();
        int who, want;
        int pat[10] = '{-1, 0, -1, -1, -1, 0, 0, 0, 1, 1};
        base0 = 8'h30; base1 = 8'hB0;
        do_reset();
        bus.req0 = 1; bus.req1 = 1;
        for (int c = 0; c < 10; c++) begin
            bus.fifo_full = (c >= 2 && c <= 4);
            @(negedge clk);
            mdl_eval();
            total_cnt++;
            if (obs !== exp_v)
                $display("FAIL stall cyc%0d: got %h want %h", c, obs, exp_v);
            else pass_cnt++;
            who = bus.fifo_wr_en ? (bus.ack1 ? 1 : 0) : -1;
            want = pat[c];
            total_cnt++;
            if (who != want)
                $display("FAIL stall pattern cyc%0d: got %0d want %0d",
                         c, who, want);
            else pass_cnt++;
            tick();
        end
        bus.fifo_full = 0;
    endtask

    task automatic test_drop();
        int run1 = 0;
        bit seen0 = 0;
        base0 = 8'h40; base1 = 8'hC0;
        do_reset();
        bus.req0 = 1;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) bus.req1 = 1;
            @(negedge clk);
            mdl_eval();
            total_cnt++;
            if (obs !== exp_v)
                $display("FAIL drop pre cyc%0d: got %h want %h", c, obs, exp_v);
            else pass_cnt++;
            tick();
        end
        bus.req0 = 0;
        @(negedge clk);
        total_cnt++;
        if (bus.fifo_wr_en !== 1'b0 || bus.owner !== 2'b01)
            $display("FAIL drop cycle: got wr=%b own=%b want 0/01",
                     bus.fifo_wr_en, bus.owner);
        else pass_cnt++;
        tick();
        bus.req0 = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            mdl_eval();
            total_cnt++;
            if (obs !== exp_v)
                $display("FAIL drop post cyc%0d: got %h want %h", c, obs, exp_v);
            else pass_cnt++;
            if (c == 0) begin
                total_cnt++;
                if (bus.owner !== 2'b10 || bus.ack1 !== 1'b1)
                    $display("FAIL drop handoff: got own=%b ack1=%b want 10/1",
                             bus.owner, bus.ack1);
                else pass_cnt++;
            end
            if (bus.ack0) seen0 = 1;
            if (bus.ack1 && !seen0) run1++;
            tick();
        end
        total_cnt++;
        if (run1 != MB)
            $display("FAIL drop burst restart: got %0d want %0d", run1, MB);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        base0 = 8'h50; base1 = 8'hD0;
        do_reset();
        bus.req0 = 1;
        tick();
        tick();
        #2;
        total_cnt++;
        if (bus.fifo_wr_en !== 1'b1 || bus.wr_count !== 16'd1)
            $display("FAIL areset pre: got wr=%b cnt=%0d want 1/1",
                     bus.fifo_wr_en, bus.wr_count);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        obs = {bus.ack0, bus.ack1, bus.fifo_wr_en, bus.owner,
               bus.fifo_data_in, bus.wr_count};
        total_cnt++;
        if (obs !== 29'd0)
            $display("FAIL areset outputs: got %h want 0", obs);
        else pass_cnt++;
        mdl_reset();
        idx0 = 0; idx1 = 0;
        bus.req1 = 1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        mdl_eval();
        total_cnt++;
        if (obs !== exp_v || bus.owner !== 2'b01)
            $display("FAIL areset restart: got %h want %h (owner 01)", obs, exp_v);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_random();
        base0 = 8'h00; base1 = 8'h80;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            bus.req0 = bus.req0 ? ($urandom_range(99) < 85)
                                : ($urandom_range(99) < 50);
            bus.req1 = bus.req1 ? ($urandom_range(99) < 85)
                                : ($urandom_range(99) < 50);
            bus.fifo_full = ($urandom_range(3) == 0);
            @(negedge clk);
            mdl_eval();
            total_cnt++;
            if (obs !== exp_v || bus.owner === 2'b11)
                $display("FAIL random cyc%0d: got %h want %h", c, obs, exp_v);
            else pass_cnt++;
            tick();
        end
        bus.req0 = 0; bus.req1 = 0; bus.fifo_full = 0;
    endtask

    task automatic test_wrap();
        int g = 0;
        base0 = 8'h00; base1 = 8'h00;
        do_reset();
        bus.req0 = 1;
        while (m_cnt != 65535 && g < 70000) begin
            tick();
            g++;
        end
        @(negedge clk);
        total_cnt++;
        if (bus.wr_count !== 16'hFFFF || bus.fifo_wr_en !== 1'b1)
            $display("FAIL wrap pre: got cnt=%0d wr=%b want 65535/1",
                     bus.wr_count, bus.fifo_wr_en);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (bus.wr_count !== 16'd0)
            $display("FAIL wrap: got %0d want 0", bus.wr_count);
        else pass_cnt++;
        bus.req0 = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_drop();
        test_async_reset();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which is the data width of each requester and of the FIFO write port.
REQ-002 SHALL have parameter MAX_BURST, default 4, which is the maximum number of consecutive accepted writes per grant while the other requester waits; legal range is 1 to 15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports req0 and req1, input, 1 bit each: the requester has a word to write.
REQ-006 SHALL have ports data0 and data1, input, WIDTH bits each: the requester's write data, held stable while its req is high.
REQ-007 SHALL have ports ack0 and ack1, output, 1 bit each: the word is accepted this cycle, and the requester advances its data on the next edge.
REQ-008 SHALL have port fifo_full, input, 1 bit: the full flag from the shared FIFO.
REQ-009 SHALL have port fifo_wr_en, output, 1 bit: the write enable to the FIFO.
REQ-010 SHALL have port fifo_data_in, output, WIDTH bits: the write data to the FIFO.
REQ-011 SHALL have port owner, output, 2 bits: 00 means idle, 01 means requester 0, 10 means requester 1.
REQ-012 SHALL have port wr_count, output, 16 bits: the total number of accepted writes since reset; it wraps.

Function
REQ-013 SHALL implement the states IDLE, OWN0 and OWN1, with a 1-bit last-owner pointer and a 4-bit burst counter.
REQ-014 In IDLE, the block SHALL assert no ack and no write; the next state is chosen from requests sampled this cycle.
REQ-015 Leaving IDLE: req0 only goes to OWN0; req1 only goes to OWN1; both go to the requester that is not the last owner; neither stays in IDLE.
REQ-016 Acceptance in OWNk SHALL be combinational: ackk = reqk AND NOT fifo_full. fifo_wr_en SHALL equal ackk, and fifo_data_in SHALL equal datak.
REQ-017 Outside an accepted cycle, fifo_data_in SHALL hold the data of the current owner, or all zeros in IDLE; the other ack SHALL be 0 at all times.
REQ-018 The burst counter SHALL increment on each accepted write and clear on every state change; fifo_full stall cycles SHALL NOT count.
REQ-019 OWNk transitions:
  - if reqk is low, go to the other owner when its req is high, else to IDLE;
  - if an accepted write brings the burst count to MAX_BURST and the other req is high, go to the other owner;
  - otherwise stay in OWNk.
REQ-020 If an accepted write reaches MAX_BURST while the other req is low, the block SHALL stay in OWNk with the burst counter cleared.
REQ-021 On every entry to OWNk, last owner SHALL be set to k.
REQ-022 A hand-off from OWNk directly to OWNj SHALL take one edge, and ackj MAY assert in the first cycle of OWNj; there is no IDLE bubble.
REQ-023 When fifo_full is high, the block SHALL hold its state, with no ack and no write. A requester that drops req while the FIFO is full SHALL be treated per REQ-019.
REQ-024 If req0 and req1 rise in the same cycle from IDLE right after reset, OWN0 SHALL win (last owner resets to 1).
REQ-025 wr_count SHALL increment by 1 on each fifo_wr_en and wrap from 65535 to 0.
REQ-026 owner SHALL decode the registered state directly (01 for OWN0, 10 for OWN1, 00 for IDLE); the value 11 SHALL never appear.

Reset
REQ-027 While rst_n is 0, independent of clk: state = IDLE, last owner = 1, burst counter = 0, wr_count = 0, owner = 00. ack0, ack1 and fifo_wr_en SHALL be 0, and fifo_data_in SHALL be all zeros.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately, with no write in the reset cycle. After release, arbitration restarts from IDLE per REQ-024.

Verification
REQ-029 Single requester: req0 high for 6 cycles with data 1..6 and fifo_full = 0 -> 1 IDLE cycle, then 6 consecutive writes of 1..6; owner = 01; wr_count = 6.
REQ-030 Contention: req0 and req1 both held high with MAX_BURST = 4 -> write pattern 0,0,0,0,1,1,1,1,0,... with no gap cycles at hand-offs.
REQ-031 Full stall: fifo_full = 1 for 3 cycles during the 2nd write of a burst -> no ack and no wr_en for those 3 cycles; the burst then resumes, and the owner switches only after 4 accepted writes.
REQ-032 Requester drop: req0 drops after 2 writes while req1 is high -> next cycle owner = 10 and ack1 = 1; the burst counter restarts at 0.
REQ-033 Async reset: rst_n pulled low mid-burst between clock edges -> fifo_wr_en, ack0/1 and owner go to 0 without a clock edge, and wr_count = 0. After release with both reqs high, owner = 01 first.
REQ-034 Counter wrap: force 65535 accepted writes, then one more -> wr_count = 0.
